stat_seg_display: RTL and testbench

Display back-end for the pipelined CPU: consumes the CPU's `Leddata` word and six performance counters and drives an 8-digit, common-anode, time-multiplexed seven-segment display. A switch-selected source is snapshotted once per refresh frame, optionally converted to decimal, and scanned one digit at a time. It sits directly downstream of the CPU top and is instantiated beside it in the board wrapper.

---
 rtl/stat_seg_display.sv | 175 +++++++++++++++++
 tb/tb_stat_seg_display.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/stat_seg_display.sv
// 8-digit multiplexed seven-segment back-end: snapshots a switch-selected source once per frame and scans it out.
// Optional decimal display of the statistics counters is enabled by defining STAT_SEG_BCD_EN.
module stat_seg_display #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  sel,
  input  logic [31:0] Leddata,
  input  logic [31:0] Count_all,
  input  logic [31:0] Count_branch,
  input  logic [31:0] Count_jmp,
  input  logic [31:0] Count_pipe,
  input  logic [31:0] Count_load_use,
  input  logic [31:0] Count_redirect,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic [1:0]  conv_state_o
);

  localparam logic [19:0] PRESC_MAX = 20'(SCAN_DIV - 1);

  logic [2:0]  sel_meta_q, sel_sync_q;
  logic [19:0] presc_q;
  logic [2:0]  idx_q;
  logic [31:0] snap_q;
  logic [2:0]  snap_sel_q;
  logic [7:0]  an_q, an_d, seg_q, seg_d;
  logic [31:0] src;
  logic [31:0] disp;
  logic        ovf;
  logic        presc_wrap, frame_start;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  assign presc_wrap  = (presc_q == PRESC_MAX);
  assign frame_start = presc_wrap && (idx_q == 3'd7);

  always_comb begin
    src = 32'h0;
    case (sel_sync_q)
      3'd0: src = Leddata;
      3'd1: src = Count_all;
      3'd2: src = Count_branch;
      3'd3: src = Count_jmp;
      3'd4: src = Count_pipe;
      3'd5: src = Count_load_use;
      3'd6: src = Count_redirect;
      default: src = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_meta_q <= 3'd0;
      sel_sync_q <= 3'd0;
      presc_q    <= 20'd0;
      idx_q      <= 3'd0;
      snap_q     <= 32'h0;
      snap_sel_q <= 3'd0;
      an_q       <= 8'hFF;
      seg_q      <= 8'hFF;
    end else begin
      sel_meta_q <= sel;
      sel_sync_q <= sel_meta_q;
      if (presc_wrap) begin
        presc_q <= 20'd0;
        idx_q   <= idx_q + 3'd1;
      end else begin
        presc_q <= presc_q + 20'd1;
      end
      if (frame_start) begin
        snap_q     <= src;
        snap_sel_q <= sel_sync_q;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

`ifdef STAT_SEG_BCD_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} conv_state_e;

  conv_state_e state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [39:0] bcd_q, bcd_d;
  logic [31:0] disp_q, disp_d;
  logic        ovf_q, ovf_d;

  // One double-dabble step: correct every BCD digit >= 5, then shift the next binary bit in.
  function automatic logic [39:0] dabble(input logic [39:0] b, input logic bit_in);
    logic [39:0] t;
    t = b;
    for (int i = 0; i < 10; i++) begin
      if (t[4*i +: 4] >= 4'd5) t[4*i +: 4] = t[4*i +: 4] + 4'd3;
    end
    dabble = {t[38:0], bit_in};
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    disp_d  = disp_q;
    ovf_d   = ovf_q;
    case (state_q)
      SHIFT: begin
        bcd_d = dabble(bcd_q, snap_q[5'd31 - cnt_q]);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = DONE;
      end
      DONE: begin
        disp_d  = bcd_q[31:0];
        ovf_d   = |bcd_q[39:32];
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A new frame always wins: restart the conversion, or abandon it for a hex/blank source.
    if (frame_start) begin
      if (sel_sync_q inside {[3'd1:3'd6]}) begin
        state_d = SHIFT;
        cnt_d   = 5'd0;
        bcd_d   = 40'h0;
      end else begin
        state_d = IDLE;
        disp_d  = src;
        ovf_d   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      bcd_q   <= 40'h0;
      disp_q  <= 32'h0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
    end
  end

  assign disp         = disp_q;
  assign ovf          = ovf_q;
  assign conv_state_o = state_q;
`else
  // Without the converter the snapshot itself is the displayed value.
  assign disp         = snap_q;
  assign ovf          = 1'b0;
  assign conv_state_o = 2'd0;
`endif

  always_comb begin
    an_d = ~(8'd1 << idx_q);
    if (snap_sel_q == 3'd7) seg_d = 8'hFF;
    else seg_d = {~(ovf && (idx_q == 3'd7)), glyph(disp[{idx_q, 2'b00} +: 4])};
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_stat_seg_display.sv
// Directed bench for stat_seg_display at SCAN_DIV=40; timing is tracked as posedge count since reset release.
module tb_stat_seg_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  sel;
  logic [31:0] Leddata, Count_all, Count_branch, Count_jmp, Count_pipe, Count_load_use, Count_redirect;
  logic [7:0]  an, seg;
  logic [1:0]  conv_state_o;

  int cyc  = 0;
  int base = 0;
  int n_vec = 0;
  int n_err = 0;

  logic [7:0] an_tab [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

  stat_seg_display #(.SCAN_DIV(40)) dut (
    .clk(clk), .rst(rst), .sel(sel), .Leddata(Leddata),
    .Count_all(Count_all), .Count_branch(Count_branch), .Count_jmp(Count_jmp),
    .Count_pipe(Count_pipe), .Count_load_use(Count_load_use), .Count_redirect(Count_redirect),
    .an(an), .seg(seg), .conv_state_o(conv_state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Park on the falling edge after posedge k (counted from reset release).
  task automatic wait_edge(input int k);
    while (cyc - base < k) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b0; sel = 3'd0; Leddata = 32'h1234ABCD;
    Count_all = 32'h11111111; Count_branch = 32'h22222222; Count_jmp = 32'h33333333;
    Count_pipe = 32'h44444444; Count_load_use = 32'h55555555; Count_redirect = 32'h66666666;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_vec++;
      if (an !== 8'hFF || seg !== 8'hFF) begin
        $display("FAIL reset_hold c%0d: an=%h seg=%h want FF FF", i, an, seg); n_err++;
      end
    end
    n_vec++;
    if (conv_state_o !== 2'd0) begin $display("FAIL reset_conv: got %0d want 0", conv_state_o); n_err++; end
    rst = 1'b1; base = cyc;
    wait_edge(1);
    n_vec++;
    if (an !== 8'hFE || seg !== 8'hC0) begin $display("FAIL reset_first: an=%h seg=%h want FE C0", an, seg); n_err++; end
    wait_edge(41);
    n_vec++;
    if (an !== 8'hFD || seg !== 8'hC0) begin $display("FAIL reset_digit1: an=%h seg=%h want FD C0", an, seg); n_err++; end
  endtask

  task automatic test_hex_scan;
    logic [7:0] exp_seg [4] = '{8'hA1, 8'hC6, 8'h83, 8'h88};
    wait_edge(320);
    n_vec++;
    if (an !== 8'h7F || seg !== 8'hC0) begin $display("FAIL hex_prev_frame: an=%h seg=%h want 7F C0", an, seg); n_err++; end
    wait_edge(321);
    n_vec++;
    if (an !== 8'hFE || seg !== 8'hA1) begin $display("FAIL hex_frame_edge: an=%h seg=%h want FE A1", an, seg); n_err++; end
    for (int d = 0; d < 4; d++) begin
      wait_edge(320 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== exp_seg[d]) begin
        $display("FAIL hex_digit%0d: an=%h seg=%h want %h %h", d, an, seg, an_tab[d], exp_seg[d]); n_err++;
      end
    end
  endtask

  task automatic test_snapshot;
    logic [7:0] exp_seg [8] = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
    wait_edge(480);
    Leddata = 32'hFFFFFFFF;
    for (int d = 4; d < 8; d++) begin
      wait_edge(320 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== exp_seg[d]) begin
        $display("FAIL snap_hold_digit%0d: an=%h seg=%h want %h %h", d, an, seg, an_tab[d], exp_seg[d]); n_err++;
      end
    end
    for (int d = 0; d < 8; d++) begin
      wait_edge(640 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== 8'h8E) begin
        $display("FAIL snap_new_digit%0d: an=%h seg=%h want %h 8E", d, an, seg, an_tab[d]); n_err++;
      end
    end
  endtask

  task automatic test_select_blank;
    wait_edge(700);
    sel = 3'd7;
    wait_edge(960);
    n_vec++;
    if (an !== 8'h7F || seg !== 8'h8E) begin $display("FAIL blank_prev: an=%h seg=%h want 7F 8E", an, seg); n_err++; end
    wait_edge(961);
    n_vec++;
    if (an !== 8'hFE || seg !== 8'hFF) begin $display("FAIL blank_edge: an=%h seg=%h want FE FF", an, seg); n_err++; end
    for (int d = 0; d < 8; d++) begin
      wait_edge(960 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== 8'hFF) begin
        $display("FAIL blank_digit%0d: an=%h seg=%h want %h FF", d, an, seg, an_tab[d]); n_err++;
      end
      if (d == 0) begin sel = 3'd2; Count_branch = 32'd5; end
    end
    for (int d = 0; d < 8; d++) begin
      wait_edge(1280 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== ((d == 0) ? 8'h92 : 8'hC0)) begin
        $display("FAIL branch_digit%0d: an=%h seg=%h want %h %h", d, an, seg, an_tab[d], (d == 0) ? 8'h92 : 8'hC0); n_err++;
      end
    end
  endtask

`ifdef STAT_SEG_BCD_EN
  task automatic test_bcd;
    logic [7:0] exp_big [8] = '{8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'h24};
    logic [7:0] exp_99  [8] = '{8'h90, 8'h90, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    wait_edge(1605);
    sel = 3'd1; Count_all = 32'd123456789;
    wait_edge(1925);
    n_vec++;
    if (conv_state_o !== 2'd1) begin $display("FAIL bcd_shift_state: got %0d want 1", conv_state_o); n_err++; end
    wait_edge(1952);
    n_vec++;
    if (conv_state_o !== 2'd2) begin $display("FAIL bcd_done_state: got %0d want 2", conv_state_o); n_err++; end
    wait_edge(1953);
    n_vec++;
    if (seg !== 8'h92 || conv_state_o !== 2'd0) begin
      $display("FAIL bcd_old_disp: seg=%h state=%0d want 92 0", seg, conv_state_o); n_err++;
    end
    wait_edge(1954);
    n_vec++;
    if (seg !== 8'h90) begin $display("FAIL bcd_new_disp: seg=%h want 90", seg); n_err++; end
    for (int d = 0; d < 8; d++) begin
      wait_edge(1920 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== exp_big[d]) begin
        $display("FAIL bcd_big_digit%0d: an=%h seg=%h want %h %h", d, an, seg, an_tab[d], exp_big[d]); n_err++;
      end
    end
    wait_edge(2236);
    Count_all = 32'd99;
    for (int d = 0; d < 8; d++) begin
      wait_edge(2240 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== exp_99[d]) begin
        $display("FAIL bcd_99_digit%0d: an=%h seg=%h want %h %h", d, an, seg, an_tab[d], exp_99[d]); n_err++;
      end
    end
  endtask
`else
  task automatic test_hex_sources;
    logic [7:0] exp_red  [8] = '{8'hA1, 8'hC0, 8'hC0, 8'h8E, 8'hA1, 8'h88, 8'h83, 8'hC0};
    logic [7:0] exp_pipe [8] = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    wait_edge(1605);
    sel = 3'd6; Count_redirect = 32'h0BADF00D;
    for (int d = 0; d < 8; d++) begin
      wait_edge(1920 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== exp_red[d]) begin
        $display("FAIL redirect_digit%0d: an=%h seg=%h want %h %h", d, an, seg, an_tab[d], exp_red[d]); n_err++;
      end
    end
    wait_edge(2236);
    sel = 3'd4; Count_pipe = 32'h87654321;
    for (int d = 0; d < 8; d++) begin
      wait_edge(2240 + 40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== exp_pipe[d]) begin
        $display("FAIL pipe_digit%0d: an=%h seg=%h want %h %h", d, an, seg, an_tab[d], exp_pipe[d]); n_err++;
      end
    end
  endtask
`endif

  task automatic test_reset_mid(input int fs);
    wait_edge(fs + 10);
    rst = 1'b0;
    #1;
    n_vec++;
    if (an !== 8'hFF || seg !== 8'hFF || conv_state_o !== 2'd0) begin
      $display("FAIL mid_reset_async: an=%h seg=%h state=%0d want FF FF 0", an, seg, conv_state_o); n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (an !== 8'hFF || seg !== 8'hFF) begin
        $display("FAIL mid_reset_hold c%0d: an=%h seg=%h want FF FF", i, an, seg); n_err++;
      end
    end
    rst = 1'b1; base = cyc;
    wait_edge(1);
    n_vec++;
    if (an !== 8'hFE || seg !== 8'hC0) begin $display("FAIL mid_reset_first: an=%h seg=%h want FE C0", an, seg); n_err++; end
    for (int d = 0; d < 8; d++) begin
      wait_edge(40*d + 35);
      n_vec++;
      if (an !== an_tab[d] || seg !== 8'hC0) begin
        $display("FAIL mid_reset_digit%0d: an=%h seg=%h want %h C0", d, an, seg, an_tab[d]); n_err++;
      end
      if (d == 2) begin
        n_vec++;
        if (conv_state_o !== 2'd0) begin $display("FAIL mid_reset_idle: got %0d want 0", conv_state_o); n_err++; end
      end
    end
  endtask

  initial begin
    test_reset;
    test_hex_scan;
    test_snapshot;
    test_select_blank;
`ifdef STAT_SEG_BCD_EN
    test_bcd;
`else
    test_hex_sources;
`endif
    test_reset_mid(2560);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
